// File: rtl/microondas_timer.sv
// Microwave cooking timer: BCD MM:SS keypad entry and a once-per-second countdown.
// Define QUICKSTART_EN to enable quick-start (start at 0000 loads QUICK_SEC, start in RUN adds 30 s).
module microondas_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int QUICK_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] display1,
  output logic [3:0] display2,
  output logic [3:0] display3,
  output logic [3:0] display4,
  output logic       magnetron_on,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   time_q, time_next, run_time;  // {min tens, min units, sec tens, sec units}
  logic [PW-1:0] presc, presc_next;
  logic          door_q;
  logic          mag_q, done_q;
  logic          tick;

  // Seconds at 00 borrow a minute and become 59; a seconds-tens digit above 5 simply counts down.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] s1, s2, m1, m2;
    {m2, m1, s2, s1} = t;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else if (s2 != 4'd0) begin
      s1 = 4'd9;
      s2 = s2 - 4'd1;
    end else begin
      s1 = 4'd9;
      s2 = 4'd5;
      if (m1 != 4'd0) begin
        m1 = m1 - 4'd1;
      end else begin
        m1 = 4'd9;
        m2 = m2 - 4'd1;
      end
    end
    return {m2, m1, s2, s1};
  endfunction

`ifdef QUICKSTART_EN
  localparam logic [15:0] QUICK_TIME = {8'h00, 4'(QUICK_SEC / 10), 4'(QUICK_SEC % 10)};

  function automatic logic [15:0] bcd_add30_sat(input logic [15:0] t);
    logic [3:0] s1, s2, m1, m2;
    {m2, m1, s2, s1} = t;
    if (s2 < 4'd3) begin
      s2 = s2 + 4'd3;
    end else if (m2 == 4'd9 && m1 == 4'd9) begin
      return 16'h9959;
    end else begin
      s2 = s2 - 4'd3;
      if (m1 == 4'd9) begin
        m1 = 4'd0;
        m2 = m2 + 4'd1;
      end else begin
        m1 = m1 + 4'd1;
      end
    end
    return {m2, m1, s2, s1};
  endfunction
`endif

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      time_q <= '0;
      presc  <= '0;
      door_q <= 1'b0;
      mag_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      time_q <= time_next;
      presc  <= presc_next;
      door_q <= door_open;
      mag_q  <= (state_next == S_RUN);
      done_q <= (state_next == S_DONE);
    end
  end

  always_comb begin
    state_next = state;
    time_next  = time_q;
    presc_next = presc;
    run_time   = time_q;
    case (state)
      S_IDLE: begin
        if (stop) begin
          time_next = '0;
        end else if (start) begin
          if (!door_open && time_q != '0) begin
            state_next = S_RUN;
            presc_next = '0;
          end
`ifdef QUICKSTART_EN
          else if (!door_open) begin
            time_next  = QUICK_TIME;
            state_next = S_RUN;
            presc_next = '0;
          end
`endif
        end else if (key_valid && key_code <= 4'd9) begin
          time_next = {time_q[11:0], key_code};
        end
      end
      S_RUN: begin
        if (door_open || stop) begin
          state_next = S_PAUSE;
        end else begin
          presc_next = tick ? '0 : presc + PW'(1);
          if (tick && time_q != '0) run_time = bcd_dec(time_q);
`ifdef QUICKSTART_EN
          if (start) run_time = bcd_add30_sat(run_time);
`endif
          time_next = run_time;
          if (run_time == '0) state_next = S_DONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_next = S_IDLE;
          time_next  = '0;
        end else if (start && !door_open) begin
          state_next = S_RUN;
          presc_next = '0;
        end
      end
      S_DONE: begin
        time_next = '0;
        if (stop || key_valid || (door_open && !door_q)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    display1     = time_q[3:0];
    display2     = time_q[7:4];
    display3     = time_q[11:8];
    display4     = time_q[15:12];
    magnetron_on = mag_q;
    done         = done_q;
  end

endmodule

// File: doc/microondas_timer.md
Name: microondas_timer

Overview:
- Cooking-time entry and countdown core of the microwave controller.
- Accepts decoded keypad digits, holds the time as four BCD digits (MM:SS), and counts down once per second while heating.
- Drives the four 4-bit digit outputs consumed directly by the display/keypad bus packer, plus magnetron and done status.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second countdown step (tests use 4).
- QUICK_SEC, 30, seconds loaded by quick-start (used only with QUICKSTART_EN); must be 0..59.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  decoded key; 0-9 are digits, 10-15 are ignored.
- start  input  1  one-cycle start/resume strobe.
- stop  input  1  one-cycle stop/clear strobe.
- door_open  input  1  level; 1 means the door is open.
- display1  output  4  BCD seconds units.
- display2  output  4  BCD seconds tens.
- display3  output  4  BCD minutes units.
- display4  output  4  BCD minutes tens.
- magnetron_on  output  1  high only in RUN.
- done  output  1  high only in DONE.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset: state=IDLE, all displays 0, magnetron_on=0, done=0, prescaler=0.
- All outputs are registered. Every response appears on the clock edge after the strobe (1-cycle latency).
- States and transitions:
  - IDLE
    - Digit key: shift left, display4<=display3, display3<=display2, display2<=display1, display1<=key_code. The oldest digit is discarded.
    - Keys 10-15: ignored.
    - stop: clear all digits to 0.
    - start with door closed and time nonzero: enter RUN.
    - start with time 0000: ignored.
  - RUN
    - Prescaler counts 0..TICK_DIV-1. It is cleared on entry to RUN.
    - When the prescaler reaches TICK_DIV-1, do one BCD decrement. The first decrement lands exactly TICK_DIV cycles after the start edge.
    - Decrement rule: display1 borrows from display2. When seconds reach 00 with minutes nonzero, minutes decrement and seconds become 59.
    - Digits above 5 entered in display2 are legal and count down naturally (e.g. 0099 -> 0098).
    - A decrement that produces 0000: enter DONE on that same edge.
    - door_open=1 or stop: enter PAUSE; time held.
    - Keys: ignored.
  - PAUSE
    - Prescaler and time held.
    - start with door closed: RUN, prescaler cleared.
    - stop: IDLE with digits cleared to 0.
    - Keys: ignored.
  - DONE
    - Time stays 0000.
    - stop, any key_valid, or door_open rising: IDLE. The key is not entered.
- Simultaneous events, priority: door_open > stop > start > key_valid.
  - start and stop in the same cycle: stop wins.
  - door_open=1 blocks every entry into RUN.
- Wrap-around:
  - 9999 is the maximum entry.
  - A fifth digit discards display4.
  - No other overflow is possible.
- Reset mid-RUN: immediate IDLE, 0000, magnetron_on=0 asynchronously.
- Digit values above 9 never appear on any display output.

Optional Feature:
- QUICKSTART_EN defined:
  - start in IDLE with time 0000 and door closed loads 00:QUICK_SEC (QUICK_SEC=30 loads display2=3, display1=0) and enters RUN on the same edge.
  - start in RUN adds 30 s with BCD carry, saturating at 9959. This rule applies when QUICK_SEC=30 and is fixed.
- QUICKSTART_EN undefined:
  - start at 0000 is ignored.
  - start in RUN is ignored.

Test Plan:
- Reset with rst pulsed asynchronously mid-cycle -> all displays 0, magnetron_on=0, done=0 immediately.
- Keys 1,2,3,4,5 in IDLE -> displays {4,3,2,1}={2,3,4,5}; keys 12 and 15 -> no change; stop -> 0000.
- TICK_DIV=4, enter 0100, start:
  - magnetron_on=1 next cycle.
  - After 4 cycles the time is 0059.
  - After 60 ticks: DONE, done=1, magnetron_on=0, time 0000.
- In RUN at 0045, raise door_open -> PAUSE, time frozen for 20 cycles; start while door open -> no change; close door, start -> resumes, next decrement 4 cycles later.
- start and stop in same cycle in RUN -> PAUSE; a second stop -> IDLE, 0000; start at 0000 -> stays IDLE (without QUICKSTART_EN) or 0030 RUN (with it).
- Enter 0099, start, 1 tick -> 0098; in DONE press key 7 -> IDLE, display1 remains 0.
